bram_sp_arb2: RTL and testbench

//   Two-client round-robin arbiter in front of one bram_sync_sp instance.

---
 rtl/bram_sp_arb2.sv | 96 +++++++++
 tb/tb_bram_sp_arb2.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bram_sp_arb2.sv
// bram_sp_arb2: two-client round-robin arbiter in front of one single-port
// synchronous BRAM. Each client presents a read/write command held under req.
// The arbiter routes one winner per cycle onto the RAM port and returns read
// data with a one-cycle rvalid strobe RD_LATENCY cycles after the grant.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cX_req/wr/addr/wdata      client X command (X = 0, 1)
//   cX_gnt                    client X command accepted this cycle
//   cX_rvalid/rdata           client X read return (rdata valid only with rvalid)
//   ram_wr/addr/data_in       to BRAM
//   ram_data_out              from BRAM
module bram_sp_arb2 #(
   parameter int unsigned RAM_DATA_WIDTH = 8,
   parameter int unsigned RAM_ADDR_WIDTH = 4,
   parameter int unsigned RD_LATENCY     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      c0_req,
   input  logic                      c0_wr,
   input  logic [RAM_ADDR_WIDTH-1:0] c0_addr,
   input  logic [RAM_DATA_WIDTH-1:0] c0_wdata,
   output logic                      c0_gnt,
   output logic                      c0_rvalid,
   output logic [RAM_DATA_WIDTH-1:0] c0_rdata,
   input  logic                      c1_req,
   input  logic                      c1_wr,
   input  logic [RAM_ADDR_WIDTH-1:0] c1_addr,
   input  logic [RAM_DATA_WIDTH-1:0] c1_wdata,
   output logic                      c1_gnt,
   output logic                      c1_rvalid,
   output logic [RAM_DATA_WIDTH-1:0] c1_rdata,
   output logic                      ram_wr,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
   input  logic [RAM_DATA_WIDTH-1:0] ram_data_out
);

   // Client id of the most recent accepted request; the other client wins a tie.
   logic                      last_q;
   logic                      win;
   logic                      granted;
   logic                      win_wr;
   logic [RAM_ADDR_WIDTH-1:0] win_addr;
   logic [RAM_DATA_WIDTH-1:0] win_wdata;

   // Read return pipeline: valid bit and client id per stage.
   logic [RD_LATENCY-1:0]     rv_q;
   logic [RD_LATENCY-1:0]     id_q;

   always_comb begin
      if (c0_req && c1_req) begin
         win = ~last_q;
      end else begin
         win = c1_req;
      end
      granted   = (c0_req | c1_req) & ~rst;
      win_wr    = win ? c1_wr    : c0_wr;
      win_addr  = win ? c1_addr  : c0_addr;
      win_wdata = win ? c1_wdata : c0_wdata;

      c0_gnt      = granted & ~win;
      c1_gnt      = granted &  win;
      ram_wr      = granted & win_wr;
      ram_addr    = granted ? win_addr  : '0;
      ram_data_in = granted ? win_wdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
         rv_q   <= '0;
         id_q   <= '0;
      end else begin
         if (granted) begin
            last_q <= win;
         end
         rv_q[0] <= granted & ~win_wr;
         id_q[0] <= win;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rv_q[i] <= rv_q[i-1];
            id_q[i] <= id_q[i-1];
         end
      end
   end

   // rvalid is also masked by rst so nothing escapes during a reset cycle.
   always_comb begin
      c0_rvalid = rv_q[RD_LATENCY-1] & ~id_q[RD_LATENCY-1] & ~rst;
      c1_rvalid = rv_q[RD_LATENCY-1] &  id_q[RD_LATENCY-1] & ~rst;
      c0_rdata  = ram_data_out;
      c1_rdata  = ram_data_out;
   end

endmodule

// File: tb/tb_bram_sp_arb2.sv
// Directed bench for bram_sp_arb2 with a behavioural single-port BRAM model
// (read latency 1). Each vector is one clock cycle: inputs applied just after
// the rising edge, outputs compared later in the same cycle.
module tb_bram_sp_arb2;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_req, c0_wr, c0_gnt, c0_rvalid;
   logic [AW-1:0] c0_addr;
   logic [DW-1:0] c0_wdata, c0_rdata;
   logic          c1_req, c1_wr, c1_gnt, c1_rvalid;
   logic [AW-1:0] c1_addr;
   logic [DW-1:0] c1_wdata, c1_rdata;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in, ram_data_out;

   logic [DW-1:0] mem [2**AW];

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   bram_sp_arb2 #(
      .RAM_DATA_WIDTH(DW),
      .RAM_ADDR_WIDTH(AW),
      .RD_LATENCY    (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .c0_req      (c0_req),
      .c0_wr       (c0_wr),
      .c0_addr     (c0_addr),
      .c0_wdata    (c0_wdata),
      .c0_gnt      (c0_gnt),
      .c0_rvalid   (c0_rvalid),
      .c0_rdata    (c0_rdata),
      .c1_req      (c1_req),
      .c1_wr       (c1_wr),
      .c1_addr     (c1_addr),
      .c1_wdata    (c1_wdata),
      .c1_gnt      (c1_gnt),
      .c1_rvalid   (c1_rvalid),
      .c1_rdata    (c1_rdata),
      .ram_wr      (ram_wr),
      .ram_addr    (ram_addr),
      .ram_data_in (ram_data_in),
      .ram_data_out(ram_data_out)
   );

   // Read-first synchronous single-port RAM.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_data_in;
      ram_data_out <= mem[ram_addr];
   end

   typedef struct {
      logic          rst;
      logic          r0, w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1, w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          g0, g1, rv0, rv1, wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rs,
                      input logic r0, input logic w0, input int a0, input int d0,
                      input logic r1, input logic w1, input int a1, input int d1,
                      input logic g0, input logic g1, input logic rv0, input logic rv1,
                      input logic wr, input int addr, input int din, input int rdata);
      vec_t v;
      v.rst = rs;
      v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
      v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1);
      v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
      v.wr = wr; v.addr = AW'(addr); v.din = DW'(din); v.rdata = DW'(rdata);
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      @(posedge clk);
      #1;
      rst = v.rst;
      c0_req = v.r0; c0_wr = v.w0; c0_addr = v.a0; c0_wdata = v.d0;
      c1_req = v.r1; c1_wr = v.w1; c1_addr = v.a1; c1_wdata = v.d1;
      #3;
      check("c0_gnt", idx, 32'(c0_gnt), 32'(v.g0));
      check("c1_gnt", idx, 32'(c1_gnt), 32'(v.g1));
      check("c0_rvalid", idx, 32'(c0_rvalid), 32'(v.rv0));
      check("c1_rvalid", idx, 32'(c1_rvalid), 32'(v.rv1));
      check("ram_wr", idx, 32'(ram_wr), 32'(v.wr));
      check("ram_addr", idx, 32'(ram_addr), 32'(v.addr));
      check("ram_data_in", idx, 32'(ram_data_in), 32'(v.din));
      if (v.rv0) check("c0_rdata", idx, 32'(c0_rdata), 32'(v.rdata));
      if (v.rv1) check("c1_rdata", idx, 32'(c1_rdata), 32'(v.rdata));
   endtask

   initial begin
      vec_t hv;
      rst = 1'b1;
      c0_req = 0; c0_wr = 0; c0_addr = '0; c0_wdata = '0;
      c1_req = 0; c1_wr = 0; c1_addr = '0; c1_wdata = '0;

      //   rst r0 w0 a0 d0      r1 w1 a1 d1      g0 g1 rv0 rv1 wr addr din rdata
      // Reset with both requesting: nothing granted.
      add(1, 1, 1, 5, 'h44,  1, 1, 7, 'h66,  0, 0, 0, 0, 0, 0, 0,    0);
      add(1, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,    0);
      // c0 writes addr 6 then reads it back.
      add(0, 1, 1, 6, 'h55,  0, 0, 0, 0,     1, 0, 0, 0, 1, 6, 'h55, 0);
      add(0, 1, 0, 6, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0, 6, 0,    0);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0,    'h55);
      // c1 preloads addrs 0..3 with 0x10..0x13; writes return nothing.
      add(0, 0, 0, 0, 0,     1, 1, 0, 'h10,  0, 1, 0, 0, 1, 0, 'h10, 0);
      add(0, 0, 0, 0, 0,     1, 1, 1, 'h11,  0, 1, 0, 0, 1, 1, 'h11, 0);
      add(0, 0, 0, 0, 0,     1, 1, 2, 'h12,  0, 1, 0, 0, 1, 2, 'h12, 0);
      add(0, 0, 0, 0, 0,     1, 1, 3, 'h13,  0, 1, 0, 0, 1, 3, 'h13, 0);
      // Simultaneous reads: c0 first (last = 1), then c1.
      add(0, 1, 0, 2, 0,     1, 0, 3, 0,     1, 0, 0, 0, 0, 2, 0,    0);
      add(0, 0, 0, 0, 0,     1, 0, 3, 0,     0, 1, 1, 0, 0, 3, 0,    'h12);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 1, 0, 0, 0,    'h13);
      // Both hold for 6 cycles: c0 writes addr 8, c1 reads addr 1; alternate.
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     1, 0, 0, 0, 1, 8, 'ha0, 0);
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     0, 1, 0, 0, 0, 1, 0,    0);
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     1, 0, 0, 1, 1, 8, 'ha0, 'h11);
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     0, 1, 0, 0, 0, 1, 0,    0);
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     1, 0, 0, 1, 1, 8, 'ha0, 'h11);
      add(0, 1, 1, 8, 'ha0,  1, 0, 1, 0,     0, 1, 0, 0, 0, 1, 0,    0);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 1, 0, 0, 0,    'h11);
      // c1 back-to-back reads of 0..3.
      add(0, 0, 0, 0, 0,     1, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0,    0);
      add(0, 0, 0, 0, 0,     1, 0, 1, 0,     0, 1, 0, 1, 0, 1, 0,    'h10);
      add(0, 0, 0, 0, 0,     1, 0, 2, 0,     0, 1, 0, 1, 0, 2, 0,    'h11);
      add(0, 0, 0, 0, 0,     1, 0, 3, 0,     0, 1, 0, 1, 0, 3, 0,    'h12);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 1, 0, 0, 0,    'h13);
      // c0 writes addr 9 (last -> 0), then idle with junk commands, req low.
      add(0, 1, 1, 9, 'h33,  0, 0, 0, 0,     1, 0, 0, 0, 1, 9, 'h33, 0);
      add(0, 0, 1, 5, 'h77,  0, 1, 7, 'h88,  0, 0, 0, 0, 0, 0, 0,    0);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,    0);
      // Conflict after idle: c1 wins since last held at 0. c0 then swaps its
      // pending command from write addr 4 to read addr 9 before its grant.
      add(0, 1, 1, 4, 'h77,  1, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0,    0);
      add(0, 1, 0, 9, 0,     0, 0, 0, 0,     1, 0, 0, 1, 0, 9, 0,    'h10);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0,    'h33);
      // c0 read followed by reset: in-flight read dropped, last back to 1.
      add(0, 1, 0, 9, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0, 9, 0,    0);
      add(1, 1, 1, 2, 'h99,  1, 1, 3, 'h98,  0, 0, 0, 0, 0, 0, 0,    0);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,    0);
      add(0, 1, 0, 2, 0,     1, 0, 3, 0,     1, 0, 0, 0, 0, 2, 0,    0);
      add(0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0,    'h12);

      foreach (vecs[i]) apply(i, vecs[i]);

      // Hand sequence: c1 loses a conflict and withdraws; no c1 return and
      // no write appears for its dropped command.
      hv = '{rst:0, r0:0, w0:0, a0:0, d0:0, r1:1, w1:0, a1:0, d1:0,
             g0:0, g1:1, rv0:0, rv1:0, wr:0, addr:0, din:0, rdata:0};
      apply(100, hv);
      hv = '{rst:0, r0:1, w0:0, a0:3, d0:0, r1:1, w1:1, a1:2, d1:'hee,
             g0:1, g1:0, rv0:0, rv1:1, wr:0, addr:3, din:0, rdata:'h10};
      apply(101, hv);
      hv = '{rst:0, r0:0, w0:0, a0:0, d0:0, r1:0, w1:1, a1:2, d1:'hee,
             g0:0, g1:0, rv0:1, rv1:0, wr:0, addr:0, din:0, rdata:'h13};
      apply(102, hv);
      // Addr 2 must still hold its preload value.
      hv = '{rst:0, r0:1, w0:0, a0:2, d0:0, r1:0, w1:0, a1:0, d1:0,
             g0:1, g1:0, rv0:0, rv1:0, wr:0, addr:2, din:0, rdata:0};
      apply(103, hv);
      hv = '{rst:0, r0:0, w0:0, a0:0, d0:0, r1:0, w1:0, a1:0, d1:0,
             g0:0, g1:0, rv0:1, rv1:0, wr:0, addr:0, din:0, rdata:'h12};
      apply(104, hv);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
